// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch PC generator and its branch target buffer.
package pc_gen_pkg;

  localparam int unsigned XLEN_DEF = 64;
  typedef logic [XLEN_DEF-1:0] addr_t;

  localparam int unsigned PC_INC         = 4;
  localparam logic [1:0]  CTR_WEAK_TAKEN = 2'b10;
  localparam logic [1:0]  CTR_MAX        = 2'b11;

  // Saturating 2-bit direction counter step.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
    end
    return (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup, synchronous update.
// Addresses are word addresses (byte address bits [XLEN-1:2]).
module pc_btb
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-3:0] lkp_word,
  output logic            lkp_taken,
  output logic [XLEN-3:0] lkp_target,
  input  logic            upd_valid,
  input  logic [XLEN-3:0] upd_word,
  input  logic            upd_taken,
  input  logic [XLEN-3:0] upd_target
);

  localparam int unsigned IDX   = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - 2 - IDX;
  localparam int unsigned TGT_W = XLEN - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [TGT_W-1:0] target;
    logic [1:0]       ctr;
  } btb_entry_t;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]         ctr_q [ENTRIES];
  logic [1:0]         ctr_d [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TGT_W-1:0]   tgt_q [ENTRIES];

  logic [IDX-1:0]   lkp_idx, upd_idx;
  logic [TAG_W-1:0] lkp_tag, upd_tag;
  btb_entry_t       lkp_e, upd_e;
  logic             upd_hit;
  logic             wr_en;

  assign lkp_idx = lkp_word[IDX-1:0];
  assign lkp_tag = lkp_word[XLEN-3:IDX];
  assign upd_idx = upd_word[IDX-1:0];
  assign upd_tag = upd_word[XLEN-3:IDX];

  // Gather the addressed entries for lookup and update.
  always_comb begin
    lkp_e        = '0;
    lkp_e.valid  = valid_q[lkp_idx];
    lkp_e.tag    = tag_q[lkp_idx];
    lkp_e.target = tgt_q[lkp_idx];
    lkp_e.ctr    = ctr_q[lkp_idx];
    upd_e        = '0;
    upd_e.valid  = valid_q[upd_idx];
    upd_e.tag    = tag_q[upd_idx];
    upd_e.target = tgt_q[upd_idx];
    upd_e.ctr    = ctr_q[upd_idx];
  end

  assign lkp_taken  = lkp_e.valid && (lkp_e.tag == lkp_tag) && lkp_e.ctr[1];
  assign lkp_target = lkp_e.target;
  assign upd_hit    = upd_e.valid && (upd_e.tag == upd_tag);

  // Hits train the counter; taken misses allocate as weakly taken.
  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    wr_en   = 1'b0;
    if (upd_valid && !rst) begin
      if (upd_hit) begin
        ctr_d[upd_idx] = ctr_step(upd_e.ctr, upd_taken);
        wr_en          = upd_taken;
      end else if (upd_taken) begin
        valid_d[upd_idx] = 1'b1;
        ctr_d[upd_idx]   = CTR_WEAK_TAKEN;
        wr_en            = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'b00;
      end
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Tag and target arrays carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[upd_idx] <= upd_tag;
      tgt_q[upd_idx] <= upd_target;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: PC register, next-PC priority mux and BTB-driven prediction.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN        = $bits(addr_t),
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_4,
  output logic [XLEN-1:0] next_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-3:0] btb_target;
  logic            unused_lsbs;

  assign unused_lsbs = ^{upd_pc[1:0], upd_target[1:0]};

  pc_btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .lkp_word   (pc_q[XLEN-1:2]),
    .lkp_taken  (pred_taken),
    .lkp_target (btb_target),
    .upd_valid  (upd_valid),
    .upd_word   (upd_pc[XLEN-1:2]),
    .upd_taken  (upd_taken),
    .upd_target (upd_target[XLEN-1:2])
  );

  assign pc          = pc_q;
  assign pc_4        = pc_q + XLEN'(PC_INC);
  assign pred_target = pred_taken ? {btb_target, 2'b00} : '0;
  assign next_pc     = pc_d;

  // Flushes (trap, redirect) outrank stall; prediction only when free-running.
  always_comb begin
    pc_d = pc_4;
    if (rst) begin
      pc_d = RESET_PC_A;
    end else if (trap_valid) begin
      pc_d = trap_pc & ALIGN_MASK;
    end else if (redirect_valid) begin
      pc_d = redirect_pc & ALIGN_MASK;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC_A;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (XLEN=64, RESET_PC=0, 16 BTB entries).
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst, stall, trap_valid, redirect_valid, upd_valid, upd_taken;
  logic [63:0] trap_pc, redirect_pc, upd_pc, upd_target;
  logic [63:0] pc, pc_4, next_pc, pred_target;
  logic        pred_taken;
  int          checks = 0;
  int          errors = 0;

  pc_gen #(.XLEN(64), .RESET_PC(64'h0), .BTB_ENTRIES(16)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .pc(pc), .pc_4(pc_4), .next_pc(next_pc),
    .pred_taken(pred_taken), .pred_target(pred_target)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic jump(input logic [63:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    tick();
    redirect_valid = 1'b0;
    #1;
  endtask

  task automatic upd(input logic [63:0] a, input logic tk, input logic [63:0] t, input int n);
    upd_valid = 1'b1; upd_pc = a; upd_taken = tk; upd_target = t;
    for (int i = 0; i < n; i++) tick();
    upd_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (pc !== 64'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 64'h0); end
    checks++; if (pc_4 !== 64'h4) begin errors++; $display("FAIL reset_pc4 got=%h exp=%h", pc_4, 64'h4); end
    checks++; if (next_pc !== 64'h0) begin errors++; $display("FAIL reset_next got=%h exp=%h", next_pc, 64'h0); end
    checks++; if (pred_taken !== 1'b0 || pred_target !== 64'h0) begin
      errors++; $display("FAIL reset_pred got=%b/%h exp=0/0", pred_taken, pred_target); end
    rst = 1'b0;
    #1;
    checks++; if (next_pc !== 64'h4) begin errors++; $display("FAIL seq_next got=%h exp=%h", next_pc, 64'h4); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (pc !== 64'(4 * i) || pred_taken !== 1'b0) begin
        errors++; $display("FAIL seq_step%0d got=%h/%b exp=%h/0", i, pc, pred_taken, 64'(4 * i)); end
    end
  endtask

  task automatic test_priority();
    trap_valid = 1'b1; redirect_valid = 1'b1; stall = 1'b1;
    trap_pc = 64'h100; redirect_pc = 64'h200;
    #1;
    checks++; if (next_pc !== 64'h100) begin errors++; $display("FAIL prio_trap_next got=%h exp=%h", next_pc, 64'h100); end
    tick();
    checks++; if (pc !== 64'h100) begin errors++; $display("FAIL prio_trap got=%h exp=%h", pc, 64'h100); end
    trap_valid = 1'b0;
    tick();
    checks++; if (pc !== 64'h200) begin errors++; $display("FAIL prio_redirect got=%h exp=%h", pc, 64'h200); end
    redirect_valid = 1'b0;
    tick(); tick();
    checks++; if (pc !== 64'h200 || next_pc !== 64'h200) begin
      errors++; $display("FAIL prio_stall got=%h/%h exp=200/200", pc, next_pc); end
    stall = 1'b0;
    #1;
  endtask

  task automatic test_btb_train();
    upd(64'h40, 1'b1, 64'h80, 1);
    jump(64'h40);
    checks++; if (pred_taken !== 1'b1 || pred_target !== 64'h80 || next_pc !== 64'h80) begin
      errors++; $display("FAIL train_pred got=%b/%h/%h exp=1/80/80", pred_taken, pred_target, next_pc); end
    tick();
    checks++; if (pc !== 64'h80) begin errors++; $display("FAIL train_follow got=%h exp=%h", pc, 64'h80); end
    upd(64'h40, 1'b0, 64'h0, 2);
    jump(64'h40);
    checks++; if (pred_taken !== 1'b0 || pred_target !== 64'h0 || next_pc !== 64'h44) begin
      errors++; $display("FAIL train_untrain got=%b/%h/%h exp=0/0/44", pred_taken, pred_target, next_pc); end
    // Counter at 0: one taken hit only reaches 1, still not predicted.
    upd(64'h40, 1'b1, 64'h90, 1);
    jump(64'h40);
    checks++; if (pred_taken !== 1'b0 || next_pc !== 64'h44) begin
      errors++; $display("FAIL train_ctr1 got=%b/%h exp=0/44", pred_taken, next_pc); end
    upd(64'h40, 1'b1, 64'h90, 1);
    jump(64'h40);
    checks++; if (pred_taken !== 1'b1 || next_pc !== 64'h90) begin
      errors++; $display("FAIL train_retarget got=%b/%h exp=1/90", pred_taken, next_pc); end
    upd(64'h40, 1'b1, 64'h90, 2);
    upd(64'h40, 1'b0, 64'h0, 1);
    jump(64'h40);
    checks++; if (pred_taken !== 1'b1 || next_pc !== 64'h90) begin
      errors++; $display("FAIL train_saturate got=%b/%h exp=1/90", pred_taken, next_pc); end
  endtask

  task automatic test_alias();
    upd(64'h80, 1'b1, 64'hC0, 1);
    jump(64'h40);
    checks++; if (pred_taken !== 1'b0 || next_pc !== 64'h44) begin
      errors++; $display("FAIL alias_old got=%b/%h exp=0/44", pred_taken, next_pc); end
    jump(64'h80);
    checks++; if (pred_taken !== 1'b1 || next_pc !== 64'hC0) begin
      errors++; $display("FAIL alias_new got=%b/%h exp=1/c0", pred_taken, next_pc); end
  endtask

  task automatic test_collision();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    jump(64'h40);
    upd_valid = 1'b1; upd_pc = 64'h40; upd_taken = 1'b1; upd_target = 64'h80;
    #1;
    checks++; if (pred_taken !== 1'b0 || next_pc !== 64'h44) begin
      errors++; $display("FAIL collide_same got=%b/%h exp=0/44", pred_taken, next_pc); end
    tick();
    upd_valid = 1'b0;
    jump(64'h40);
    checks++; if (pred_taken !== 1'b1 || next_pc !== 64'h80) begin
      errors++; $display("FAIL collide_next got=%b/%h exp=1/80", pred_taken, next_pc); end
  endtask

  task automatic test_update_during_stall();
    stall = 1'b1;
    upd(64'h20, 1'b1, 64'h60, 1);
    checks++; if (pc !== 64'h40) begin errors++; $display("FAIL stall_hold got=%h exp=%h", pc, 64'h40); end
    stall = 1'b0;
    jump(64'h20);
    checks++; if (pred_taken !== 1'b1 || next_pc !== 64'h60) begin
      errors++; $display("FAIL stall_upd got=%b/%h exp=1/60", pred_taken, next_pc); end
  endtask

  task automatic test_midrun_reset();
    rst = 1'b1;
    upd_valid = 1'b1; upd_pc = 64'h10; upd_taken = 1'b1; upd_target = 64'h30;
    #1;
    checks++; if (next_pc !== 64'h0) begin errors++; $display("FAIL rst_next got=%h exp=%h", next_pc, 64'h0); end
    tick();
    rst = 1'b0; upd_valid = 1'b0;
    #1;
    checks++; if (pc !== 64'h0 || pred_taken !== 1'b0) begin
      errors++; $display("FAIL rst_pc got=%h/%b exp=0/0", pc, pred_taken); end
    jump(64'h40);
    checks++; if (pred_taken !== 1'b0 || next_pc !== 64'h44) begin
      errors++; $display("FAIL rst_inval got=%b/%h exp=0/44", pred_taken, next_pc); end
    jump(64'h10);
    checks++; if (pred_taken !== 1'b0 || next_pc !== 64'h14) begin
      errors++; $display("FAIL rst_drop_upd got=%b/%h exp=0/14", pred_taken, next_pc); end
  endtask

  task automatic test_wrap();
    jump(64'hFFFF_FFFF_FFFF_FFFF);
    checks++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++; $display("FAIL wrap_align got=%h exp=%h", pc, 64'hFFFF_FFFF_FFFF_FFFC); end
    checks++; if (pc_4 !== 64'h0 || next_pc !== 64'h0) begin
      errors++; $display("FAIL wrap_pc4 got=%h/%h exp=0/0", pc_4, next_pc); end
    tick();
    checks++; if (pc !== 64'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=%h", pc, 64'h0); end
    trap_valid = 1'b1; trap_pc = 64'h103;
    tick();
    trap_valid = 1'b0;
    #1;
    checks++; if (pc !== 64'h100) begin errors++; $display("FAIL trap_align got=%h exp=%h", pc, 64'h100); end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; trap_valid = 1'b0; redirect_valid = 1'b0; upd_valid = 1'b0;
    upd_taken = 1'b0; trap_pc = '0; redirect_pc = '0; upd_pc = '0; upd_target = '0;
    test_reset();
    test_priority();
    test_btb_train();
    test_alias();
    test_collision();
    test_update_during_stall();
    test_midrun_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
